// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-serial memory arbiter: FSM states, access size codes,
// default I/O region select and helpers for byte count and load extension.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] IO_SEL_DEF = 2'b11;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] sz,
                                           input logic uns);
    logic [31:0] r;
    case (sz)
      SZ_B:    r = uns ? {24'd0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      SZ_H:    r = uns ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-requester round-robin grant (bit0 fetch, bit1 load/store); grant is combinational,
// last_grant updates only on an accepted grant while rdy is high.
module mem_arb_rr (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  logic last_grant; // 0: fetch won last, 1: load/store won last

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant <= 1'b0;
    else if (rdy && take) last_grant <= gnt[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial RAM/IO controller: fetch done in cycle 6 after grant, loads N+2, stores N+1;
// rdy low freezes everything (mem_wr forced 0). MEM_ARB_PERF_CNT_EN adds done-pulse counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_SEL = IO_SEL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_store,
  input  logic [1:0]        ls_size,
  input  logic              ls_unsigned,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata
`ifdef MEM_ARB_PERF_CNT_EN
 ,output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_ls_cnt
`endif
);

  state_t            state;
  logic [2:0]        cnt;
  logic [2:0]        nbytes;
  logic              cur_if;
  logic              cur_uns;
  logic              cur_io;
  logic [1:0]        cur_size;
  logic              wr_q;
  logic [31:0]       wbuf;
  logic [31:0]       rbuf;
  logic [31:0]       assembled;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              take;
  logic              ls_io;
  logic              stall_q;
  logic [7:0]        din_hold;
  logic [7:0]        din_eff;
  logic [ADDR_W-1:0] a_inc;

  assign req    = {ls_req & ~ls_done, if_req & ~if_done};
  assign take   = (state == ST_IDLE) && !flush && (|req);
  assign ls_io  = (ls_addr[17:16] == IO_SEL);
  assign mem_wr = wr_q & rdy;
  assign a_inc  = mem_a + {{(ADDR_W-1){1'b0}}, 1'b1};

  mem_arb_rr u_rr (
    .clk  (clk),
    .rst  (rst),
    .rdy  (rdy),
    .req  (req),
    .take (take),
    .gnt  (gnt)
  );

  // The RAM keeps answering during a stall, so mem_din in the first frozen cycle is the byte
  // still owed to the pipeline; later stall cycles already show the next address's data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= 1'b0;
      din_hold <= 8'd0;
    end else if (!rdy) begin
      if (!stall_q) din_hold <= mem_din;
      stall_q <= 1'b1;
    end else begin
      stall_q <= 1'b0;
    end
  end

  assign din_eff = stall_q ? din_hold : mem_din;

  always_comb begin
    assembled = rbuf;
    case (cnt)
      3'd1:    assembled[7:0]   = din_eff;
      3'd2:    assembled[15:8]  = din_eff;
      3'd3:    assembled[23:16] = din_eff;
      default: assembled[31:24] = din_eff;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      nbytes   <= 3'd0;
      cur_if   <= 1'b0;
      cur_uns  <= 1'b0;
      cur_io   <= 1'b0;
      cur_size <= SZ_B;
      wr_q     <= 1'b0;
      wbuf     <= 32'd0;
      rbuf     <= 32'd0;
      mem_a    <= '0;
      mem_dout <= 8'd0;
      if_done  <= 1'b0;
      if_data  <= 32'd0;
      ls_done  <= 1'b0;
      ls_rdata <= 32'd0;
    end else if (rdy) begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            cnt  <= 3'd0;
            rbuf <= 32'd0;
            if (gnt[0]) begin
              cur_if <= 1'b1;
              nbytes <= 3'd4;
              mem_a  <= if_addr;
              state  <= ST_READ;
            end else if (gnt[1]) begin
              cur_if   <= 1'b0;
              cur_size <= ls_size;
              cur_uns  <= ls_unsigned;
              nbytes   <= size_bytes(ls_size);
              mem_a    <= ls_addr;
              if (ls_store) begin
                state    <= ST_WRITE;
                wbuf     <= ls_wdata;
                mem_dout <= ls_wdata[7:0];
                cur_io   <= ls_io;
                wr_q     <= !(ls_io && io_buffer_full);
              end else begin
                state <= ST_READ;
              end
            end
          end
        end
        ST_READ: begin
          if (flush) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
            mem_a <= '0;
          end else begin
            if (cnt != 3'd0) rbuf <= assembled;
            if (cnt == nbytes) begin
              state <= ST_IDLE;
              cnt   <= 3'd0;
              if (cur_if) begin
                if_data <= assembled;
                if_done <= 1'b1;
              end else begin
                ls_rdata <= load_ext(assembled, cur_size, cur_uns);
                ls_done  <= 1'b1;
              end
            end else begin
              cnt <= cnt + 3'd1;
              // park the bus on 0 once the last address has been issued
              mem_a <= (cnt + 3'd1 == nbytes) ? '0 : a_inc;
            end
          end
        end
        ST_WRITE: begin
          if (wr_q) begin
            if (cnt + 3'd1 == nbytes) begin
              state   <= ST_IDLE;
              cnt     <= 3'd0;
              wr_q    <= 1'b0;
              ls_done <= 1'b1;
            end else begin
              cnt      <= cnt + 3'd1;
              mem_a    <= a_inc;
              mem_dout <= wbuf[15:8];
              wbuf     <= {8'd0, wbuf[31:8]};
              wr_q     <= !(cur_io && io_buffer_full);
            end
          end else begin
            wr_q <= !(cur_io && io_buffer_full);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_ls_cnt    <= 32'd0;
    end else if (rdy) begin
      if (if_done) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (ls_done) perf_ls_cnt    <= perf_ls_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: byte RAM model, expected fetch/load/write queues.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_store;
  logic [1:0]  ls_size;
  logic        ls_unsigned;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_ls_cnt;
`endif

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full),
    .flush          (flush),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_data        (if_data),
    .ls_req         (ls_req),
    .ls_store       (ls_store),
    .ls_size        (ls_size),
    .ls_unsigned    (ls_unsigned),
    .ls_addr        (ls_addr),
    .ls_wdata       (ls_wdata),
    .ls_done        (ls_done),
    .ls_rdata       (ls_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
   ,.perf_fetch_cnt (perf_fetch_cnt),
    .perf_ls_cnt    (perf_ls_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int n_spur_wr = 0;
  int n_spur_if = 0;
  int n_spur_ls = 0;
  int n_both = 0;

  logic [7:0]  ram [0:262143];
  logic [31:0] exp_if [$];
  logic [32:0] exp_ls [$];
  logic [39:0] exp_wr [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read RAM; byte k's data appears the cycle after its address
  always @(posedge clk) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) ram[mem_a[17:0]] = mem_dout;
  end

  always @(negedge clk) begin
    logic [39:0] w;
    logic [32:0] e;
    if (!rst) begin
      if (mem_wr) begin
        last_wr_cyc = cyc;
        if (exp_wr.size() == 0) n_spur_wr++;
        else begin
          w = exp_wr.pop_front();
          chk("wr_byte", 64'({mem_a, mem_dout}), 64'(w));
        end
      end
      if (rdy && if_done && ls_done) n_both++;
      if (rdy && if_done) begin
        if (exp_if.size() == 0) n_spur_if++;
        else chk("if_data", 64'(if_data), 64'(exp_if.pop_front()));
      end
      if (rdy && ls_done) begin
        if (exp_ls.size() == 0) n_spur_ls++;
        else begin
          e = exp_ls.pop_front();
          if (e[32]) chk("st_drain", 64'(exp_wr.size()), 64'd0);
          else chk("ls_rdata", 64'(ls_rdata), 64'(e[31:0]));
        end
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) ram[a[17:0] + 18'(k)] = d[8*k +: 8];
  endtask

  task automatic run_fetch(input logic [31:0] a, input logic [31:0] d, input int lat);
    int  t0;
    bit  seen;
    exp_if.push_back(d);
    if_addr = a;
    if_req  = 1'b1;
    t0   = cyc;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rdy && if_done) seen = 1'b1;
    end
    if (!seen) chk("if_timeout", 64'd0, 64'd1);
    else chk("if_lat", 64'(cyc - t0), 64'(lat));
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic run_ls(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_d, input int lat);
    int t0;
    int n;
    bit seen;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (st) for (int k = 0; k < n; k++) exp_wr.push_back({a + 32'(k), wd[8*k +: 8]});
    exp_ls.push_back({st, exp_d});
    ls_store    = st;
    ls_size     = sz;
    ls_unsigned = uns;
    ls_addr     = a;
    ls_wdata    = wd;
    ls_req      = 1'b1;
    t0   = cyc;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rdy && ls_done) seen = 1'b1;
    end
    if (!seen) chk("ls_timeout", 64'd0, 64'd1);
    else chk("ls_lat", 64'(cyc - t0), 64'(lat));
    @(posedge clk); #1;
    ls_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_store = 1'b0;
    ls_size = 2'd0; ls_unsigned = 1'b0; ls_addr = '0; ls_wdata = '0;
    preload(32'h100, 32'h00100513);
    preload(32'h300, 32'h80010080);
    preload(32'h400, 32'h87654321);
    preload(32'h500, 32'hddccbbaa);
    idle(3);
    chk("rst_mem_a",   64'(mem_a), 64'd0);
    chk("rst_mem_wr",  64'(mem_wr), 64'd0);
    chk("rst_mem_dout",64'(mem_dout), 64'd0);
    chk("rst_if_done", 64'(if_done), 64'd0);
    chk("rst_ls_done", 64'(ls_done), 64'd0);
    chk("rst_if_data", 64'(if_data), 64'd0);
    chk("rst_ls_rdata",64'(ls_rdata), 64'd0);
    rst = 1'b0;
    idle(2);

    // plain word fetch
    run_fetch(32'h100, 32'h00100513, 6);
    idle(1);

    // both request, last grant was fetch: store goes first, fetch right after ls_done
    fork
      run_ls(1'b1, 2'd2, 1'b0, 32'h200, 32'hDEADBEEF, 32'd0, 5);
      run_fetch(32'h100, 32'h00100513, 11);
    join
    idle(1);
    run_ls(1'b0, 2'd2, 1'b0, 32'h200, 32'd0, 32'hDEADBEEF, 6);
    idle(1);
    // last grant was load/store: fetch wins this time
    fork
      run_fetch(32'h100, 32'h00100513, 6);
      run_ls(1'b0, 2'd0, 1'b0, 32'h300, 32'd0, 32'hFFFFFF80, 9);
    join
    idle(1);

    // load extension
    run_ls(1'b0, 2'd0, 1'b1, 32'h300, 32'd0, 32'h00000080, 3);
    run_ls(1'b0, 2'd1, 1'b0, 32'h302, 32'd0, 32'hFFFF8001, 4);
    run_ls(1'b0, 2'd1, 1'b1, 32'h302, 32'd0, 32'h00008001, 4);
    idle(1);

    // flush after two fetch bytes, then an immediate new fetch
    if_addr = 32'h500;
    if_req  = 1'b1;
    idle(4);
    flush  = 1'b1;
    if_req = 1'b0;
    idle(1);
    flush = 1'b0;
    run_fetch(32'h100, 32'h00100513, 6);
    idle(1);

    // flush during a store does not abort it
    fork
      run_ls(1'b1, 2'd2, 1'b0, 32'h210, 32'h11223344, 32'd0, 5);
      begin idle(2); flush = 1'b1; idle(1); flush = 1'b0; end
    join
    idle(1);

    // I/O store held off by a full UART buffer
    t0 = cyc;
    fork
      run_ls(1'b1, 2'd0, 1'b0, 32'h30000, 32'h00000041, 32'd0, 5);
      begin io_buffer_full = 1'b1; idle(3); io_buffer_full = 1'b0; end
    join
    chk("io_wr_cyc", 64'(last_wr_cyc - t0), 64'd4);
    idle(1);

    // global stall mid-load and mid-store
    fork
      run_ls(1'b0, 2'd2, 1'b0, 32'h400, 32'd0, 32'h87654321, 10);
      begin idle(3); rdy = 1'b0; idle(4); rdy = 1'b1; end
    join
    idle(1);
    fork
      run_ls(1'b1, 2'd2, 1'b0, 32'h220, 32'hCAFEF00D, 32'd0, 8);
      begin idle(2); rdy = 1'b0; idle(3); rdy = 1'b1; end
    join
    idle(1);
    run_ls(1'b0, 2'd2, 1'b0, 32'h220, 32'd0, 32'hCAFEF00D, 6);
    idle(1);

    // reset in the middle of a store
    exp_wr.push_back({32'h240, 8'h55});
    ls_store = 1'b1; ls_size = 2'd2; ls_unsigned = 1'b0;
    ls_addr = 32'h240; ls_wdata = 32'h44332255; ls_req = 1'b1;
    idle(2);
    chk("pre_rst_wr", 64'(mem_wr), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_wr",   64'(mem_wr), 64'd0);
    chk("rst_mid_a",    64'(mem_a), 64'd0);
    chk("rst_mid_done", 64'(ls_done), 64'd0);
    ls_req = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(1);
    run_fetch(32'h100, 32'h00100513, 6);
`ifdef MEM_ARB_PERF_CNT_EN
    chk("perf_fetch", 64'(perf_fetch_cnt), 64'd1);
    chk("perf_ls",    64'(perf_ls_cnt), 64'd0);
`endif
    idle(3);

    chk("exp_if_left", 64'(exp_if.size()), 64'd0);
    chk("exp_ls_left", 64'(exp_ls.size()), 64'd0);
    chk("exp_wr_left", 64'(exp_wr.size()), 64'd0);
    chk("spur_wr",     64'(n_spur_wr), 64'd0);
    chk("spur_if",     64'(n_spur_if), 64'd0);
    chk("spur_ls",     64'(n_spur_ls), 64'd0);
    chk("both_done",   64'(n_both), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
